// File: rtl/linear_layer_start_fifo_srl.sv
// Start-token FIFO built on a shift-register (SRL) store: writes shift in at
// position 0 and the oldest token is read from position count-1.

module linear_layer_start_fifo_srl_shiftreg #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  ce,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] q
);

  // Storage is deliberately not reset; occupancy tracking makes stale data unreachable.
  logic [DATA_WIDTH-1:0] sr [DEPTH];

  always_ff @(posedge clk) begin
    if (ce) begin
      sr[0] <= data;
      for (int i = 1; i < DEPTH; i++) begin
        sr[i] <= sr[i-1];
      end
    end
  end

  always_comb begin
    q = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (addr == ADDR_WIDTH'(i)) begin
        q = sr[i];
      end
    end
  end

endmodule

module linear_layer_start_fifo_srl #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_write,
  input  logic                  if_write_ce,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  input  logic                  if_read,
  input  logic                  if_read_ce,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
  output logic [ADDR_WIDTH:0]   occupancy
);

  // Handshake: a token moves in only when if_write & if_write_ce & if_full_n are
  // all high at a rising edge, and moves out only when if_read & if_read_ce &
  // if_empty_n are all high. Both flags are registered, so a request never
  // combinationally affects the flag it is qualified by.
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);

  logic                  push;
  logic                  pop;
  logic [ADDR_WIDTH:0]   count;
  logic [ADDR_WIDTH:0]   count_next;
  logic [ADDR_WIDTH:0]   count_m1;
  logic [ADDR_WIDTH-1:0] addr;

  assign push = if_write & if_write_ce & if_full_n;
  assign pop  = if_read  & if_read_ce  & if_empty_n;

  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + 1'b1;
    end else if (pop && !push) begin
      count_next = count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count      <= '0;
      if_full_n  <= 1'b1;
      if_empty_n <= 1'b0;
    end else begin
      count      <= count_next;
      if_full_n  <= (count_next != DEPTH_C);
      if_empty_n <= (count_next != '0);
    end
  end

  // The oldest token sits one below the fill level once anything is stored.
  assign count_m1  = count - 1'b1;
  assign addr      = (count != '0) ? count_m1[ADDR_WIDTH-1:0] : '0;
  assign occupancy = count;

  linear_layer_start_fifo_srl_shiftreg #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_shiftreg (
    .clk  (clk),
    .ce   (push),
    .data (if_din),
    .addr (addr),
    .q    (if_dout)
  );

endmodule

// File: tb/tb_linear_layer_start_fifo_srl.sv
// Scoreboard bench for linear_layer_start_fifo_srl: a queue model tracks the
// stored tokens, flags and occupancy and is compared every cycle.

module tb_linear_layer_start_fifo_srl;

  localparam int DATA_WIDTH = 1;
  localparam int ADDR_WIDTH = 1;
  localparam int DEPTH      = 2;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  if_write;
  logic                  if_write_ce;
  logic [DATA_WIDTH-1:0] if_din;
  logic                  if_full_n;
  logic                  if_read;
  logic                  if_read_ce;
  logic [DATA_WIDTH-1:0] if_dout;
  logic                  if_empty_n;
  logic [ADDR_WIDTH:0]   occupancy;

  logic [DATA_WIDTH-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  // clock / reset
  always #5 clk = ~clk;

  linear_layer_start_fifo_srl #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .if_write    (if_write),
    .if_write_ce (if_write_ce),
    .if_din      (if_din),
    .if_full_n   (if_full_n),
    .if_read     (if_read),
    .if_read_ce  (if_read_ce),
    .if_dout     (if_dout),
    .if_empty_n  (if_empty_n),
    .occupancy   (occupancy)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One cycle: check outputs against the model, drive inputs, update the
  // model with what should be accepted, then advance past the edge.
  task automatic drive(input logic w, input logic wce, input logic [DATA_WIDTH-1:0] d,
                       input logic r, input logic rce, input logic rst);
    bit do_push;
    bit do_pop;
    check_val("occupancy", 32'(occupancy), 32'(exp_q.size()));
    check_val("full_n", 32'(if_full_n), 32'(exp_q.size() != DEPTH));
    check_val("empty_n", 32'(if_empty_n), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check_val("dout", 32'(if_dout), 32'(exp_q[0]));
    end
    reset       = rst;
    if_write    = w;
    if_write_ce = wce;
    if_din      = d;
    if_read     = r;
    if_read_ce  = rce;
    do_push = w && wce && (exp_q.size() != DEPTH);
    do_pop  = r && rce && (exp_q.size() != 0);
    if (rst) begin
      exp_q.delete();
    end else begin
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) exp_q.push_back(d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b1, '0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic wr(input logic [DATA_WIDTH-1:0] d);
    drive(1'b1, 1'b1, d, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic rd();
    drive(1'b0, 1'b1, '0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic wr_rd(input logic [DATA_WIDTH-1:0] d);
    drive(1'b1, 1'b1, d, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    reset = 1'b1; if_write = 1'b0; if_write_ce = 1'b1; if_din = '0;
    if_read = 1'b0; if_read_ce = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // idle after reset
    repeat (5) idle();

    // fill, overflow attempt, drain
    wr(1'b1); wr(1'b0); wr(1'b1);
    rd(); rd(); idle();

    // occupancy 1, simultaneous write/read
    wr(1'b1); wr_rd(1'b0); idle(); rd(); idle();

    // full, simultaneous write/read: only pop
    wr(1'b1); wr(1'b0); wr_rd(1'b1); idle(); rd(); idle();

    // empty, simultaneous write/read: only push
    wr_rd(1'b1); idle(); rd(); idle();

    // reset mid-operation, then read side frozen by ce
    wr(1'b1); wr(1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    idle();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    idle();
    // write side frozen by ce while full_n high
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    rd(); idle();

    // random traffic
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
            DATA_WIDTH'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 49) == 0));
    end
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/linear_layer_start_fifo_srl.md
Name: linear_layer_start_fifo_srl

Overview:
- Start-token FIFO between two dataflow processes of the Linear_Layer_i4xi4_q kernel, e.g. a producer and a PE_i4xi4_pack_2x2 stage.
- Owns and instantiates the SRL shift-register storage array.
- Supplies the shift-enable and the read address that select the oldest entry.
- Provides the full_n/empty_n handshake toward the writing process and the reading process.

Parameters:
- DATA_WIDTH, 1, width of each token. Start tokens are 1 bit.
- ADDR_WIDTH, 1, width of the storage read address. Must satisfy 2^ADDR_WIDTH >= DEPTH.
- DEPTH, 2, number of entries. Must be >= 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- if_write  in  1  producer write request.
- if_write_ce  in  1  producer clock-enable; gates if_write.
- if_din  in  DATA_WIDTH  token to enqueue.
- if_full_n  out  1  high = space available.
- if_read  in  1  consumer read request.
- if_read_ce  in  1  consumer clock-enable; gates if_read.
- if_dout  out  DATA_WIDTH  oldest stored token.
- if_empty_n  out  1  high = token available.
- occupancy  out  ADDR_WIDTH+1  current entry count, 0..DEPTH; used for debug and verification.

Behaviour:
- Handshake qualification:
  - push = if_write & if_write_ce & if_full_n.
  - pop = if_read & if_read_ce & if_empty_n.
  - Requests with the flag low are ignored with no side effects.
- Storage: DEPTH x DATA_WIDTH shift register, not reset.
  - On push: every entry moves one position deeper and if_din enters position 0.
- Read address: addr = count-1 when count > 0, else 0. The oldest entry is therefore always at addr.
- if_dout = storage[addr], combinational from the address.
  - Value is undefined when if_empty_n=0; the bench must not check it then.
- count register, ADDR_WIDTH+1 bits, updates each cycle:
  - push only: count+1.
  - pop only: count-1.
  - push & pop: unchanged. The shift and the read happen in the same cycle.
  - neither: unchanged.
- Flags are registered, computed from the next count:
  - if_full_n(next) = (count_next != DEPTH).
  - if_empty_n(next) = (count_next != 0).
  - No combinational path from if_write/if_read to either flag.
- occupancy = count.
- Reset values: count=0, if_full_n=1, if_empty_n=0, occupancy=0.
  - Reset mid-operation discards all tokens regardless of concurrent push/pop. Storage contents are left as-is but are unreachable.
- Latency:
  - Token pushed in cycle t: if_empty_n high and if_dout valid at t+1.
  - Pop in cycle t: if_full_n high at t+1.
- Boundary conditions:
  - Empty with write+read: only the push is accepted; count 0->1.
  - Full with write+read: only the pop is accepted (if_full_n=0 blocks the write); count DEPTH->DEPTH-1. The producer retries.
  - Nonempty and non-full with write+read: the token popped is the pre-shift oldest value (storage[count-1] before the edge).
  - DEPTH=1: addr is constantly 0; the flags toggle complementarily.
  - count never wraps: push is impossible at DEPTH and pop is impossible at 0.
- if_write_ce=0 or if_read_ce=0 freezes that side completely, even while the request is high.

Test Plan:
- Reset then idle 5 cycles -> if_full_n=1, if_empty_n=0, occupancy=0 every cycle.
- DEPTH=2: push 1 then 0 on consecutive cycles -> occupancy 1 then 2, if_full_n=0 after the second. if_dout=1 from the cycle after the first push. A third write with din=1 is ignored and occupancy stays 2. Then pop twice -> if_dout 1 then 0; if_empty_n=0 after the second pop.
- Occupancy 1 (token 1), simultaneous write din=0 and read -> read returns 1; occupancy stays 1; next if_dout=0.
- Full (DEPTH=2, tokens 1,0), simultaneous write din=1 and read -> only the pop occurs. Occupancy 1, if_full_n=1 next cycle, if_dout=0.
- Empty, write din=1 and read together -> push only: occupancy 1, if_empty_n=1 next cycle, if_dout=1.
- Occupancy 2, assert reset together with write+read -> next cycle occupancy 0, if_empty_n=0, if_full_n=1. Then if_read_ce=0 with if_write=1, if_read=1 -> push accepted, no pop, occupancy 1.
